// File: rtl/dmem_lsu.sv
// RV32 data memory with load/store front end: byte/half/word access, extension, 1-cycle registered response.
// Optional per-byte even parity storage and checking when DMEM_PARITY_EN is defined.
module dmem_lsu #(
  parameter int unsigned ADDR_W         = 10,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err_code,
  output logic        busy
);

  localparam int unsigned IDX_W = ADDR_W - 2;
  localparam int unsigned DEPTH = 2 ** IDX_W;

  typedef enum logic {INIT, READY} stateT;

  stateT             state, stateNext;
  logic [IDX_W-1:0]  clrCnt, clrCntNext;
  logic              readyQ, busyQ, readyNext, busyNext, clrWe;

  logic [31:0]       mem [DEPTH];
  logic [IDX_W-1:0]  wordIdx;
  logic [1:0]        byteOff;
  logic              accept;
  logic [3:0]        byteEn;
  logic [31:0]       laneData, readWord, shifted, loadData;
  logic              rangeErr, funct3Err, misErr, parErr;
  logic [1:0]        errCode;

  logic              rspValidQ;
  logic [31:0]       rspRdataQ;
  logic [1:0]        rspErrQ;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= CLEAR_ON_RESET ? INIT : READY;
      clrCnt <= '0;
    end else begin
      state  <= stateNext;
      clrCnt <= clrCntNext;
    end
  end

  // Next state: sweep one word per cycle, leave INIT after the last word
  always_comb begin
    stateNext  = state;
    clrCntNext = clrCnt;
    if (state == INIT) begin
      clrCntNext = clrCnt + IDX_W'(1);
      if (clrCnt == IDX_W'(DEPTH - 1)) stateNext = READY;
    end
  end

  // FSM outputs; ready/busy are registered from the next state
  always_comb begin
    clrWe     = (state == INIT);
    readyNext = (stateNext == READY);
    busyNext  = (stateNext == INIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      readyQ <= 1'b0;
      busyQ  <= CLEAR_ON_RESET;
    end else begin
      readyQ <= readyNext;
      busyQ  <= busyNext;
    end
  end

  assign accept  = req_valid & readyQ;
  assign wordIdx = req_addr[ADDR_W-1:2];
  assign byteOff = req_addr[1:0];
  assign readWord = mem[wordIdx];

  // Request decode: lane enables, store lane replication, load extraction
  always_comb begin
    byteEn   = 4'b1111;
    laneData = req_wdata;
    case (req_funct3[1:0])
      2'd0: begin
        byteEn   = 4'(4'b0001 << byteOff);
        laneData = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        byteEn   = byteOff[1] ? 4'b1100 : 4'b0011;
        laneData = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase

    shifted = readWord >> {byteOff, 3'b000};
    case (req_funct3[1:0])
      2'd0:    loadData = req_funct3[2] ? {24'd0, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
      2'd1:    loadData = req_funct3[2] ? {16'd0, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
      default: loadData = readWord;
    endcase
  end

`ifdef DMEM_PARITY_EN
  logic [3:0] parMem [DEPTH];
  logic [3:0] readPar, calcPar, wrPar;

  always_comb begin
    readPar = parMem[wordIdx];
    for (int b = 0; b < 4; b++) begin
      calcPar[b] = ^readWord[8*b +: 8];
      wrPar[b]   = ^laneData[8*b +: 8];
    end
    parErr = |((readPar ^ calcPar) & byteEn);
  end
`else
  assign parErr = 1'b0;
`endif

  // Error priority: range/illegal funct3, then misalignment, then load parity
  always_comb begin
    rangeErr  = |req_addr[31:ADDR_W];
    funct3Err = req_we ? (req_funct3 > 3'd2)
                       : (req_funct3 == 3'd3 || req_funct3[2:1] == 2'b11);
    misErr    = (req_funct3[1:0] == 2'd1 && byteOff[0]) ||
                (req_funct3[1:0] == 2'd2 && byteOff != 2'd0);
    errCode   = 2'b00;
    if (rangeErr || funct3Err)  errCode = 2'b10;
    else if (misErr)            errCode = 2'b01;
    else if (!req_we && parErr) errCode = 2'b11;
  end

  // Array write port (not reset); the clear sweep owns it during INIT
  always_ff @(posedge clk) begin
    if (clrWe) begin
      mem[clrCnt] <= '0;
    end else if (accept && req_we && errCode == 2'b00) begin
      for (int b = 0; b < 4; b++)
        if (byteEn[b]) mem[wordIdx][8*b +: 8] <= laneData[8*b +: 8];
    end
  end

`ifdef DMEM_PARITY_EN
  always_ff @(posedge clk) begin
    if (clrWe) begin
      parMem[clrCnt] <= '0;
    end else if (accept && req_we && errCode == 2'b00) begin
      for (int b = 0; b < 4; b++)
        if (byteEn[b]) parMem[wordIdx][b] <= wrPar[b];
    end
  end
`endif

  // Response register; data/code hold when nothing was accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rspValidQ <= 1'b0;
      rspRdataQ <= '0;
      rspErrQ   <= '0;
    end else begin
      rspValidQ <= accept;
      if (accept) begin
        rspRdataQ <= (!req_we && errCode == 2'b00) ? loadData : 32'd0;
        rspErrQ   <= errCode;
      end
    end
  end

  assign req_ready    = readyQ;
  assign busy         = busyQ;
  assign rsp_valid    = rspValidQ;
  assign rsp_rdata    = rspRdataQ;
  assign rsp_err_code = rspErrQ;

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: byte-array reference model, directed cases then random traffic.
module tb_dmem_lsu;

  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 2 ** (AW - 2);
  localparam int unsigned BYTES = 2 ** AW;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, busy;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err_code;

  dmem_lsu #(.ADDR_W(AW), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err_code(rsp_err_code),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  err;
    int          cyc;
  } expT;

  expT         expQ[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  bit          checkOn = 0;
  bit          haveLast = 0;
  logic [31:0] lastR;
  logic [1:0]  lastE;
  logic [7:0]  refMem [BYTES];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: memory as a plain byte array, access size 1/2/4 bytes
  task automatic refAccess(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata, output logic [1:0] err);
    int n, a;
    logic [31:0] v;
    n = 1 << f3[1:0];
    a = int'(addr[AW-1:0]);
    rdata = 32'd0;
    if (addr >= BYTES || (we && f3 > 3'd2) || (!we && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)))
      err = 2'd2;
    else if (a % n != 0)
      err = 2'd1;
    else begin
      err = 2'd0;
      if (we) begin
        for (int i = 0; i < n; i++) refMem[a + i] = wdata[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = refMem[a + i];
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
        rdata = v;
      end
    end
  endtask

  task automatic issueExp(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] expR, input logic [1:0] expE);
    chk("req_ready", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    expQ.push_back('{expR, expE, cyc});
    @(negedge clk);
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] r;
    logic [1:0]  e;
    refAccess(we, f3, addr, wdata, r, e);
    issueExp(we, f3, addr, wdata, r, e);
  endtask

  // Directed case: model still tracks state, expectation is the fixed value
  task automatic issueK(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] expR, input logic [1:0] expE);
    logic [31:0] r;
    logic [1:0]  e;
    refAccess(we, f3, addr, wdata, r, e);
    issueExp(we, f3, addr, wdata, expR, expE);
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: pop on every response, flag spurious/missing/late responses and idle-hold violations
  always @(negedge clk) begin
    expT e;
    if (rst_n && checkOn) begin
      if (rsp_valid) begin
        tests++;
        if (expQ.size() == 0) begin
          fails++;
          $display("FAIL spurious_rsp: got rdata %h code %0d with nothing outstanding", rsp_rdata, rsp_err_code);
        end else begin
          e = expQ.pop_front();
          if (rsp_rdata !== e.rdata || rsp_err_code !== e.err || cyc != e.cyc + 1) begin
            fails++;
            $display("FAIL rsp: got rdata %h code %0d cyc %0d, expected rdata %h code %0d cyc %0d",
                     rsp_rdata, rsp_err_code, cyc, e.rdata, e.err, e.cyc + 1);
          end
        end
        lastR = rsp_rdata;
        lastE = rsp_err_code;
        haveLast = 1;
      end else begin
        if (expQ.size() > 0 && expQ[0].cyc + 1 <= cyc) begin
          e = expQ.pop_front();
          tests++;
          fails++;
          $display("FAIL missing_rsp: got rsp_valid 0 expected 1 (rdata %h code %0d)", e.rdata, e.err);
        end
        if (haveLast) begin
          tests++;
          if (rsp_rdata !== lastR || rsp_err_code !== lastE) begin
            fails++;
            $display("FAIL idle_hold: got %h/%0d expected %h/%0d", rsp_rdata, rsp_err_code, lastR, lastE);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [2:0]  legal [8];
    legal = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2};

    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", 32'(rsp_err_code), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);

    // Release, then re-assert reset at sweep cycle 5: sweep must restart in full
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("sweep_busy", {30'd0, busy, req_ready}, 32'b10);
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", {30'd0, busy, req_ready}, 32'b10);
    rst_n = 1'b1;
    n = 0;
    while (!req_ready && n < 4 * DEPTH) begin
      @(negedge clk);
      n++;
      if (!req_ready) chk("sweep_busy2", 32'(busy), 32'd1);
    end
    chk("sweep_len", 32'(n), 32'(DEPTH));
    chk("busy_done", 32'(busy), 32'd0);

    for (int i = 0; i < BYTES; i++) refMem[i] = 8'h00;
    checkOn = 1;

    // Cleared contents
    issueK(0, 3'd2, 32'((DEPTH - 1) * 4), 32'd0, 32'h0, 2'd0);
    issueK(0, 3'd2, 32'h0, 32'd0, 32'h0, 2'd0);

    // Width and extension
    issueK(1, 3'd2, 32'h10, 32'h8081_7F80, 32'h0, 2'd0);
    issueK(0, 3'd0, 32'h10, 32'd0, 32'hFFFF_FF80, 2'd0);
    issueK(0, 3'd4, 32'h10, 32'd0, 32'h0000_0080, 2'd0);
    issueK(0, 3'd1, 32'h12, 32'd0, 32'hFFFF_8081, 2'd0);
    issueK(0, 3'd5, 32'h12, 32'd0, 32'h0000_8081, 2'd0);
    issueK(0, 3'd0, 32'h11, 32'd0, 32'h0000_007F, 2'd0);

    // Partial stores merge into one word
    issueK(1, 3'd2, 32'h20, 32'h1122_3344, 32'h0, 2'd0);
    issueK(1, 3'd0, 32'h21, 32'h0000_00AA, 32'h0, 2'd0);
    issueK(1, 3'd1, 32'h22, 32'h0000_BEEF, 32'h0, 2'd0);
    issueK(0, 3'd2, 32'h20, 32'd0, 32'hBEEF_AA44, 2'd0);
    idle(2);

    // Back-to-back store then load to the same word
    issueK(1, 3'd2, 32'h40, 32'hCAFE_F00D, 32'h0, 2'd0);
    issueK(0, 3'd2, 32'h40, 32'd0, 32'hCAFE_F00D, 2'd0);
    idle(3);

    // Errors
    issueK(0, 3'd2, 32'h6, 32'd0, 32'h0, 2'd1);
    issueK(1, 3'd1, 32'h5, 32'h1234, 32'h0, 2'd1);
    issueK(0, 3'd2, 32'h4, 32'd0, 32'h0, 2'd0);
    issueK(0, 3'd2, 32'h400, 32'd0, 32'h0, 2'd2);
    issueK(0, 3'd3, 32'h0, 32'd0, 32'h0, 2'd2);
    issueK(0, 3'd2, 32'h402, 32'd0, 32'h0, 2'd2);
    issueK(1, 3'd2, 32'h104, 32'hDEAD_BEEF, 32'h0, 2'd2);
    issueK(1, 3'd4, 32'h4, 32'hDEAD_BEEF, 32'h0, 2'd2);
    issueK(0, 3'd2, 32'h4, 32'd0, 32'h0, 2'd0);
    issueK(0, 3'd2, 32'h10, 32'd0, 32'h8081_7F80, 2'd0);
    idle(1);

    // Parity corruption on byte 0 of word 2
    issueK(1, 3'd2, 32'h8, 32'h0000_00FF, 32'h0, 2'd0);
    idle(2);
`ifdef DMEM_PARITY_EN
    dut.parMem[2] = dut.parMem[2] ^ 4'b0001;
    issueK(0, 3'd0, 32'h8, 32'd0, 32'h0, 2'd3);
    issueK(0, 3'd0, 32'h9, 32'd0, 32'h0, 2'd0);
`else
    issueK(0, 3'd0, 32'h8, 32'd0, 32'hFFFF_FFFF, 2'd0);
    issueK(0, 3'd0, 32'h9, 32'd0, 32'h0, 2'd0);
`endif
    issueK(1, 3'd2, 32'h8, 32'h0000_00FF, 32'h0, 2'd0);
    idle(2);

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      we = 1'($urandom_range(0, 1));
      f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : legal[$urandom_range(0, 7)];
      addr = 32'($urandom_range(0, BYTES - 1));
      if ($urandom_range(0, 15) == 0) addr[$urandom_range(AW, 31)] = 1'b1;
      issue(we, f3, addr, $urandom);
    end
    idle(2);

    n = 0;
    while (expQ.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drained", 32'(expQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
